alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Signal bundle between the ALU sequencer and its switches, buttons, external ALU and display.
// The sequencer takes the slave side; whatever drives the switches and hosts the ALU takes the master side.
interface alu_sequencer_if #(
    parameter int WIDTH     = 4,
    parameter int SEL_WIDTH = 4
);
    logic [WIDTH-1:0]     sw;
    logic                 btn_next;
    logic                 btn_clear;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [SEL_WIDTH-1:0] alu_sel;
    logic [WIDTH-1:0]     alu_result;
    logic [4:0]           alu_flags;
    logic [WIDTH-1:0]     disp_value;
    logic [4:0]           disp_flags;
    logic [2:0]           state_code;
    logic                 busy;
    logic                 done;
    logic [7:0]           op_count;

    modport slave (
        input  sw, btn_next, btn_clear, alu_result, alu_flags,
        output alu_a, alu_b, alu_sel, disp_value, disp_flags,
               state_code, busy, done, op_count
    );

    modport master (
        output sw, btn_next, btn_clear, alu_result, alu_flags,
        input  alu_a, alu_b, alu_sel, disp_value, disp_flags,
               state_code, busy, done, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Steps a user through entering A, B and an opcode on switches, holds them on an external ALU
// for EXEC_CYCLES cycles, then captures and displays the result and flags.
module alu_sequencer #(
    parameter int WIDTH       = 4,
    parameter int SEL_WIDTH   = 4,
    parameter int EXEC_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_e;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_e               state_q;
    logic                 btn_prev_q;
    logic [3:0]           exec_cnt_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [SEL_WIDTH-1:0] alu_sel_q;
    logic [WIDTH-1:0]     result_q;
    logic [4:0]           flags_q;
    logic                 busy_q;
    logic                 done_q;
    logic [7:0]           op_count_q;

    logic                 next_edge;
    logic [7:0]           op_count_d;

    assign next_edge  = bus.btn_next & ~btn_prev_q;
    assign op_count_d = op_count_q + 8'd1;

    // The edge-detect register keeps tracking the button in every state, so a press held
    // through S_EXEC cannot turn into a late advance once the result is showing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            btn_prev_q <= 1'b0;
            exec_cnt_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            btn_prev_q <= bus.btn_next;
            done_q     <= 1'b0;
            if (bus.btn_clear) begin
                state_q    <= S_A;
                exec_cnt_q <= '0;
                alu_a_q    <= '0;
                alu_b_q    <= '0;
                alu_sel_q  <= '0;
                result_q   <= '0;
                flags_q    <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (next_edge) begin
                            alu_a_q <= bus.sw;
                            state_q <= S_B;
                        end
                    end
                    S_B: begin
                        if (next_edge) begin
                            alu_b_q <= bus.sw;
                            state_q <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (next_edge) begin
                            alu_sel_q  <= SEL_WIDTH'(bus.sw);
                            exec_cnt_q <= EXEC_LOAD;
                            busy_q     <= 1'b1;
                            state_q    <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (exec_cnt_q == 4'd0) begin
                            result_q   <= bus.alu_result;
                            flags_q    <= bus.alu_flags;
                            done_q     <= 1'b1;
                            op_count_q <= op_count_d;
                            busy_q     <= 1'b0;
                            state_q    <= S_SHOW;
                        end else begin
                            exec_cnt_q <= exec_cnt_q - 4'd1;
                        end
                    end
                    S_SHOW: begin
                        if (next_edge) begin
                            state_q <= S_A;
                        end
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    // While operands are being entered the display echoes the switches.
    assign bus.disp_value = (state_q == S_EXEC || state_q == S_SHOW) ? result_q : bus.sw;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.disp_flags = flags_q;
    assign bus.state_code = state_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a small ALU model drives the DUT, a per-operation
// reference model is compared every cycle, and directed sequences pin key literal values.
module tb_alu_sequencer;
    localparam int WIDTH       = 4;
    localparam int SEL_WIDTH   = 4;
    localparam int EXEC_CYCLES = 2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;

    logic clk;
    logic rst;

    alu_sequencer_if #(.WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH)) bus ();

    alu_sequencer #(
        .WIDTH(WIDTH), .SEL_WIDTH(SEL_WIDTH), .EXEC_CYCLES(EXEC_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU: returns {carryOut, oVerflow, carryF, negative, zero, result}.
    function automatic logic [8:0] aluFn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] sel);
        logic [4:0] wide;
        logic [3:0] res;
        logic       c;
        logic       v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (sel)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[3:0];
                c    = wide[4];
                v    = (a[3] == b[3]) && (res[3] != a[3]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[3:0];
                c    = wide[4];
                v    = (a[3] != b[3]) && (res[3] != a[3]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = a ^ b;
        endcase
        return {c, v, c, res[3], (res == 4'd0), res};
    endfunction

    always_comb {bus.alu_flags, bus.alu_result} = aluFn(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase 0..4 = A, B, OP, EXEC, SHOW; the result lands a fixed
    // EXEC_CYCLES clock edges after the opcode is accepted.
    int         mState = 0;
    logic [3:0] mA = '0, mB = '0, mSel = '0, mRes = '0;
    logic [4:0] mFlags = '0;
    int         mCount = 0;
    bit         mDone = 0;
    bit         mPrev = 0;
    longint     cyc = 0;
    longint     execStart = 0;

    always @(posedge clk) begin : model
        bit         pressed;
        logic [8:0] alu;
        cyc++;
        pressed = bus.btn_next && !mPrev;
        mPrev   = bus.btn_next;
        mDone   = 0;
        if (rst) begin
            mState = 0; mA = '0; mB = '0; mSel = '0; mRes = '0; mFlags = '0;
            mCount = 0; mPrev = 0;
        end else if (bus.btn_clear) begin
            mState = 0; mA = '0; mB = '0; mSel = '0; mRes = '0; mFlags = '0;
        end else begin
            case (mState)
                0: if (pressed) begin mA = bus.sw; mState = 1; end
                1: if (pressed) begin mB = bus.sw; mState = 2; end
                2: if (pressed) begin mSel = bus.sw; mState = 3; execStart = cyc; end
                3: if (cyc - execStart == EXEC_CYCLES) begin
                       alu    = aluFn(mA, mB, mSel);
                       mRes   = alu[3:0];
                       mFlags = alu[8:4];
                       mDone  = 1;
                       mCount = (mCount + 1) % 256;
                       mState = 4;
                   end
                default: if (pressed) mState = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("state_code", bus.state_code, mState);
            checkOutput("alu_a", bus.alu_a, mA);
            checkOutput("alu_b", bus.alu_b, mB);
            checkOutput("alu_sel", bus.alu_sel, mSel);
            checkOutput("disp_value", bus.disp_value, (mState >= 3) ? mRes : bus.sw);
            checkOutput("disp_flags", bus.disp_flags, mFlags);
            checkOutput("busy", bus.busy, (mState == 3));
            checkOutput("done", bus.done, mDone);
            checkOutput("op_count", bus.op_count, mCount);
        end
    end

    task automatic applyStimulus(input logic [3:0] s, input bit nxt, input bit clr, input bit rs);
        @(posedge clk);
        #1;
        bus.sw        = s;
        bus.btn_next  = nxt;
        bus.btn_clear = clr;
        rst           = rs;
    endtask

    task automatic pressNext(input logic [3:0] s);
        applyStimulus(s, 1'b1, 1'b0, 1'b0);
        applyStimulus(s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runOp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         output int busyCycles, output bit sawDone);
        if (mState == 4) pressNext(4'd0);
        pressNext(a);
        pressNext(b);
        pressNext(op);
        busyCycles = 0;
        sawDone    = 0;
        for (int i = 0; i < 20 && !sawDone; i++) begin
            @(negedge clk);
            if (bus.done) sawDone = 1;
            else if (bus.busy) busyCycles++;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        bit sawDone;

        rst           = 1'b1;
        bus.sw        = '0;
        bus.btn_next  = 1'b0;
        bus.btn_clear = 1'b0;

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        checkEn = 1;
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_state", bus.state_code, 3'd0);
        checkOutput("reset_op_count", bus.op_count, 8'd0);
        checkOutput("reset_busy_done", {bus.busy, bus.done}, 2'b00);

        $display("[TB] 3 + 5 basic add");
        runOp(4'd3, 4'd5, OP_ADD, busyCycles, sawDone);
        checkOutput("add_done_seen", sawDone, 1'b1);
        checkOutput("add_busy_cycles", busyCycles, 2);
        checkOutput("add_disp_value", bus.disp_value, 4'd8);
        checkOutput("add_op_count", bus.op_count, 8'd1);
        checkOutput("add_state", bus.state_code, 3'd4);

        $display("[TB] 7 + 1 signed overflow");
        runOp(4'd7, 4'd1, OP_ADD, busyCycles, sawDone);
        checkOutput("ovf_done_seen", sawDone, 1'b1);
        checkOutput("ovf_disp_value", bus.disp_value, 4'b1000);
        checkOutput("ovf_flags", bus.disp_flags, 5'b01010);
        checkOutput("ovf_op_count", bus.op_count, 8'd2);

        $display("[TB] held button gives one advance");
        pressNext(4'd0);
        for (int i = 0; i < 10; i++) applyStimulus(4'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hold_state", bus.state_code, 3'd1);
        checkOutput("hold_alu_a", bus.alu_a, 4'd9);
        applyStimulus(4'd9, 1'b0, 1'b0, 1'b0);

        $display("[TB] clear beats next in S_OP");
        pressNext(4'd4);
        applyStimulus(4'd6, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("clr_state", bus.state_code, 3'd0);
        checkOutput("clr_operands", {bus.alu_a, bus.alu_b, bus.alu_sel}, 12'h000);
        checkOutput("clr_flags", bus.disp_flags, 5'b00000);
        checkOutput("clr_op_count", bus.op_count, 8'd2);

        $display("[TB] presses during execution are ignored");
        pressNext(4'd2);
        pressNext(4'd1);
        applyStimulus(OP_SUB, 1'b1, 1'b0, 1'b0);
        applyStimulus(OP_SUB, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ign_state", bus.state_code, 3'd4);
        checkOutput("ign_disp_value", bus.disp_value, 4'd1);
        checkOutput("ign_op_count", bus.op_count, 8'd3);

        $display("[TB] op_count wrap");
        for (int i = 0; i < 252; i++) begin
            runOp(4'(i % 16), 4'((i * 3) % 16), 4'(i % 5), busyCycles, sawDone);
            if (!sawDone) checkOutput("wrap_done_timeout", sawDone, 1'b1);
        end
        checkOutput("wrap_count_255", bus.op_count, 8'd255);
        runOp(4'd1, 4'd1, OP_AND, busyCycles, sawDone);
        checkOutput("wrap_done_seen", sawDone, 1'b1);
        checkOutput("wrap_count_0", bus.op_count, 8'd0);
        checkOutput("wrap_result", bus.disp_value, 4'd1);

        $display("[TB] reset in second exec cycle");
        runOp(4'd5, 4'd6, OP_OR, busyCycles, sawDone);
        pressNext(4'd0);
        pressNext(4'd5);
        pressNext(4'd6);
        pressNext(OP_ADD);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_exec_done", bus.done, 1'b0);
        checkOutput("rst_exec_state", bus.state_code, 3'd0);
        checkOutput("rst_exec_outputs",
                    {bus.alu_a, bus.alu_b, bus.alu_sel, bus.disp_value, bus.disp_flags},
                    21'd0);
        checkOutput("rst_exec_count_busy", {bus.op_count, bus.busy}, 9'd0);

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
